module_keypad_scan_ctrl: RTL and testbench
==========================================

# module_keypad_scan_ctrl

- Scan controller for the 4x4 matrix keypad.
- Drives the active-low column lines one at a time and samples the active-low row lines through a 2-FF synchronizer.
- Debounces press and release, then emits a one-cycle `key_valid` pulse with a 4-bit key code.
- Sits between the keypad pins and the downstream digit/operand logic; its code map matches `module_detector` (digits 0-9 as value, A=10, B=11, C=12, D=13, *=14, #=15).

## Interface

Parameters:
- `SCAN_TICKS`, default 50000: clock cycles each column is driven in scan mode; must be ≥ 4.
- `DEBOUNCE_TICKS`, default 500000: consecutive stable cycles required to accept a press or a release; must be ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `row`  in  4  keypad rows, active-low, asynchronous to `clk`; 4'b1111 = nothing pressed.
- `column`  out  4  column drive, active-low, one-hot-zero; bit n low selects column n.
- `key_code`  out  4  code of the last accepted key; held until the next accept.
- `key_valid`  out  1  one-cycle pulse when a new debounced press is accepted.
- `key_held`  out  1  high from the accept until the release is debounced.

## Operation

- `row` passes through a 2-FF synchronizer to give `row_s`. All decisions use `row_s` only.
- Column sequence: 4'b1110 → 4'b1101 → 4'b1011 → 4'b0111 → wraps to 4'b1110.
- Key map by row r / column c:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: *, 0, #, D
- If several rows are low at once, the lowest-index low row wins.
- FSM states: S_SCAN, S_DEBOUNCE, S_HOLD, S_RELEASE.
- **S_SCAN**
  - `dwell` counts 0..SCAN_TICKS-1 on the current column.
  - At `dwell == SCAN_TICKS-1`: if `row_s != 4'b1111`, capture `row_s` into `row_cap` and go to S_DEBOUNCE with the column frozen.
  - Otherwise advance to the next column and clear `dwell`.
- **S_DEBOUNCE**
  - The column stays frozen.
  - Each cycle `row_s == row_cap`: increment `db_cnt`.
  - Any mismatch (bounce or release): clear `db_cnt`, return to S_SCAN on the next column; no output change.
  - When `db_cnt` reaches DEBOUNCE_TICKS-1: load `key_code` from (`row_cap`, column), pulse `key_valid`, set `key_held`, go to S_HOLD.
- **S_HOLD**
  - The column stays frozen.
  - Wait for `row_s == 4'b1111`, then clear `db_cnt` and go to S_RELEASE.
  - A held key never produces another pulse (no auto-repeat).
- **S_RELEASE**
  - Requires DEBOUNCE_TICKS consecutive cycles of `row_s == 4'b1111`.
  - Any low row: back to S_HOLD.
  - On completion: clear `key_held`, advance to the next column, go to S_SCAN with `dwell` = 0.
- Reset mid-operation: all state returns to reset values immediately; a pulse in flight is dropped; a key still pressed is re-debounced and re-reported.

## Timing

Reset values:
- `column` = 4'b1110
- `key_code` = 4'd0
- `key_valid` = 0
- `key_held` = 0
- state = S_SCAN, all counters 0

Latency and timing rules:
- Synchronizer latency is 2 cycles; because SCAN_TICKS ≥ 4, the sample at the end of a dwell reflects the currently driven column.
- Press latency: `key_valid` rises DEBOUNCE_TICKS cycles after the S_SCAN sample cycle.
- `key_code` and `key_held` update in the same cycle that `key_valid` rises.
- `key_valid` is exactly one cycle wide.
- Release latency: `key_held` falls DEBOUNCE_TICKS cycles after `row_s` first reads all-high in S_HOLD.
- No press can be reported while `key_held` = 1.
- A release and a new press on a different column are serialized: the new key is found on a later scan.
- All outputs are registered.

## Structure

- Package `keypad_pkg` holds:
  - state enum `scan_state_t`
  - key code constants `KEY_A`..`KEY_HASH`
  - `ROW_IDLE` = 4'b1111, `COL_FIRST` = 4'b1110
  - function `f_key_decode(row, col)` returning 4 bits
- Sub-module `module_sync2`: 4-bit 2-FF synchronizer, reset to 4'b1111.
- Counters are sized with `$clog2` of their respective parameter.

## Test plan

Bench settings:
- Parameters SCAN_TICKS=4, DEBOUNCE_TICKS=8.
- Keypad model: `row[r]` is low while key (r,c) is pressed and `column[c]` = 0.

Scenarios:
- **Reset:** assert `rst` for 3 cycles mid-scan → `column` = 4'b1110, `key_valid` = 0, `key_held` = 0, `key_code` = 0 asynchronously; after release, `column` rotates every 4 cycles.
- **Full keymap:** press each of the 16 keys in turn, release between presses → exactly one `key_valid` per key, with codes 1,2,3,10,4,5,6,11,7,8,9,12,14,0,15,13.
- **Bounce:** press '5' with 3 cycles on / 2 off ×3, then stable → no pulse during the bounce; a single pulse with `key_code` = 5 exactly 8 cycles after the first stable sample.
- **Hold:** hold 'D' for 200 cycles → one pulse with code 13; `key_held` high throughout; it falls 8 cycles after release.
- **Two keys at once:** press (r2,c0) and (r0,c0) together → `key_code` = 1 (lowest row wins).
- **Reset during debounce:** reset while pressing '0' → no pulse before the reset; after reset, a pulse with code 0 and `key_held` = 1.

Source files
------------

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scan controller:
//   scan_state_t  - controller FSM states
//   KEY_A..KEY_HASH - codes of the non-digit keys (same map as module_detector)
//   ROW_IDLE      - row pattern with nothing pressed (rows are active-low)
//   COL_FIRST     - first column drive pattern after reset (column 0 low)
//   f_key_decode  - (row, column) pattern pair -> 4-bit key code
//   f_col_next    - next column in the scan rotation
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HOLD,
        S_RELEASE
    } scan_state_t;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    localparam logic [3:0] ROW_IDLE  = 4'b1111;
    localparam logic [3:0] COL_FIRST = 4'b1110;

    // Rotate the single low bit one place up: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    function automatic logic [3:0] f_col_next(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

    // Lowest-index low row wins when several rows are low. An all-high row
    // never reaches here because a press is only captured on a non-idle row.
    function automatic logic [3:0] f_key_decode(input logic [3:0] row,
                                                input logic [3:0] col);
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] code;

        if (!row[0])      r = 2'd0;
        else if (!row[1]) r = 2'd1;
        else if (!row[2]) r = 2'd2;
        else              r = 2'd3;

        if (!col[0])      c = 2'd0;
        else if (!col[1]) c = 2'd1;
        else if (!col[2]) c = 2'd2;
        else              c = 2'd3;

        case ({r, c})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = KEY_A;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = KEY_B;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'hA:    code = 4'd9;
            4'hB:    code = KEY_C;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'd0;
            4'hE:    code = KEY_HASH;
            4'hF:    code = KEY_D;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/module_keypad_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// module_keypad_scan_ctrl_if
// Pin-side and result-side signals of the keypad scan controller.
//   row       keypad rows, active-low, asynchronous to the controller clock
//   column    column drive, active-low, at most one bit low
//   key_code  code of the last accepted key
//   key_valid one-cycle pulse on each newly accepted press
//   key_held  high from accept until the release is debounced
// master: the scan controller.  slave: keypad pins plus downstream consumer.
// -----------------------------------------------------------------------------
interface module_keypad_scan_ctrl_if;

    logic [3:0] row;
    logic [3:0] column;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output column,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  column,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/module_sync2.sv
// -----------------------------------------------------------------------------
// module_sync2
// Two-flop synchronizer for the 4 keypad row lines. Resets to the idle row
// pattern so a reset never looks like a key press.
//   clk  in   system clock
//   rst  in   asynchronous active-high reset
//   d    in   4-bit asynchronous input
//   q    out  4-bit synchronized output, 2 cycles of latency
// -----------------------------------------------------------------------------
module module_sync2
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_p0;
    logic [3:0] sync_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= ROW_IDLE;
            sync_p1 <= ROW_IDLE;
        end else begin
            // stage 0: first flop may go metastable
            meta_p0 <= d;
            // stage 1: resolved copy used by the controller
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/module_keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// module_keypad_scan_ctrl
// Scan controller for a 4x4 active-low matrix keypad. Walks a single low bit
// across the columns, samples the synchronized rows at the end of each column
// dwell, debounces press and release, and reports each accepted press once.
//   SCAN_TICKS      cycles each column is driven while scanning (>= 4)
//   DEBOUNCE_TICKS  stable cycles needed to accept a press or a release (>= 2)
//   clk             system clock
//   rst             asynchronous active-high reset
//   kp.row          keypad rows in (active-low, asynchronous)
//   kp.column       column drive out (active-low, one-hot-zero)
//   kp.key_code     last accepted key code, held until the next accept
//   kp.key_valid    one-cycle pulse on an accepted press
//   kp.key_held     high from accept until release is debounced
// -----------------------------------------------------------------------------
module module_keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 50000,
    parameter int DEBOUNCE_TICKS = 500000
) (
    input  logic                       clk,
    input  logic                       rst,
    module_keypad_scan_ctrl_if.master  kp
);

    localparam int DWELL_W = $clog2(SCAN_TICKS);
    localparam int DB_W    = $clog2(DEBOUNCE_TICKS);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_TICKS - 1);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_TICKS - 1);

    logic [3:0]         row_s;
    scan_state_t        state;
    logic [DWELL_W-1:0] dwell;
    logic [DB_W-1:0]    db_cnt;
    logic [3:0]         row_cap;
    logic [3:0]         column_q;
    logic [3:0]         key_code_q;
    logic               key_valid_q;
    logic               key_held_q;

    module_sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (kp.row),
        .q   (row_s)
    );

    // The column only moves in S_SCAN (dwell expired on an idle row), on a
    // failed debounce, or when a release completes; in every other state it
    // stays frozen on the column that produced the press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_SCAN;
            dwell       <= '0;
            db_cnt      <= '0;
            row_cap     <= ROW_IDLE;
            column_q    <= COL_FIRST;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;

            unique case (state)
                S_SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        // SCAN_TICKS >= 4 covers the 2-cycle synchronizer, so
                        // this sample belongs to the column being driven now.
                        if (row_s != ROW_IDLE) begin
                            row_cap <= row_s;
                            db_cnt  <= '0;
                            state   <= S_DEBOUNCE;
                        end else begin
                            column_q <= f_col_next(column_q);
                            dwell    <= '0;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end

                S_DEBOUNCE: begin
                    if (row_s == row_cap) begin
                        if (db_cnt == DB_LAST) begin
                            key_code_q  <= f_key_decode(row_cap, column_q);
                            key_valid_q <= 1'b1;
                            key_held_q  <= 1'b1;
                            state       <= S_HOLD;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end else begin
                        // Bounce or early release: give up silently and move on.
                        db_cnt   <= '0;
                        column_q <= f_col_next(column_q);
                        dwell    <= '0;
                        state    <= S_SCAN;
                    end
                end

                S_HOLD: begin
                    // No auto-repeat: only a full debounced release leaves here.
                    if (row_s == ROW_IDLE) begin
                        db_cnt <= '0;
                        state  <= S_RELEASE;
                    end
                end

                S_RELEASE: begin
                    if (row_s != ROW_IDLE) begin
                        db_cnt <= '0;
                        state  <= S_HOLD;
                    end else if (db_cnt == DB_LAST) begin
                        key_held_q <= 1'b0;
                        db_cnt     <= '0;
                        column_q   <= f_col_next(column_q);
                        dwell      <= '0;
                        state      <= S_SCAN;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_SCAN;
                end
            endcase
        end
    end

    assign kp.column    = column_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_module_keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_module_keypad_scan_ctrl
// Bench for the keypad scan controller with SCAN_TICKS=4, DEBOUNCE_TICKS=8.
// A combinational keypad model pulls row r low while key (r,c) is pressed and
// column c is driven low. Expected codes come from the key table below and
// expected timing from the scan/debounce rules worked out in each task.
// -----------------------------------------------------------------------------
module tb_module_keypad_scan_ctrl;

    localparam int SCAN = 4;
    localparam int DEB  = 8;

    // Key code by index r*4+c.
    localparam logic [3:0] KEY_TBL [16] = '{
        4'd1,  4'd2, 4'd3,  4'd10,
        4'd4,  4'd5, 4'd6,  4'd11,
        4'd7,  4'd8, 4'd9,  4'd12,
        4'd14, 4'd0, 4'd15, 4'd13
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pressed = '0;
    logic [3:0]  row_v;
    int          checks = 0;
    int          errors = 0;

    module_keypad_scan_ctrl_if kp ();

    module_keypad_scan_ctrl #(
        .SCAN_TICKS     (SCAN),
        .DEBOUNCE_TICKS (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // Keypad matrix model.
    always_comb begin
        row_v = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.column[c]) row_v[r] = 1'b0;
    end
    assign kp.row = row_v;

    // Two-cycle delayed view of the rows and, for each of the last DEB+1
    // edges, the delayed value in force at that edge (index 0 = latest edge).
    logic [3:0] rs1_m, rs_m;
    logic [3:0] seen_hist [0:DEB];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_m <= 4'b1111;
            rs_m  <= 4'b1111;
            for (int i = 0; i <= DEB; i++) seen_hist[i] <= 4'b1111;
        end else begin
            seen_hist[0] <= rs_m;
            for (int i = 1; i <= DEB; i++) seen_hist[i] <= seen_hist[i-1];
            rs1_m <= row_v;
            rs_m  <= rs1_m;
        end
    end

    // Longest run of consecutive high key_valid cycles seen anywhere.
    int valid_run = 0;
    int max_valid_run = 0;
    always @(negedge clk) begin
        if (kp.key_valid) begin
            valid_run <= valid_run + 1;
            if (valid_run + 1 > max_valid_run) max_valid_run <= valid_run + 1;
        end else begin
            valid_run <= 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference helpers ----------------
    function automatic int ref_col(input logic [15:0] m);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (m[r*4+c]) return c;
        return 0;
    endfunction

    function automatic logic [3:0] ref_code(input logic [15:0] m);
        int c;
        c = ref_col(m);
        for (int r = 0; r < 4; r++)
            if (m[r*4+c]) return KEY_TBL[r*4+c];
        return 4'd0;
    endfunction

    function automatic logic [3:0] ref_row(input logic [15:0] m);
        logic [3:0] rv;
        int c;
        c = ref_col(m);
        rv = 4'b1111;
        for (int r = 0; r < 4; r++)
            if (m[r*4+c]) rv[r] = 1'b0;
        return rv;
    endfunction

    // A press is accepted only after the scan sample plus DEB debounce edges
    // all saw the same row pattern.
    function automatic bit window_ok(input logic [3:0] exp_row);
        for (int i = 0; i <= DEB; i++)
            if (seen_hist[i] !== exp_row) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Press a key mask, wait for the accept, hold, release, and check the
    // release timing: rows go high now, the delayed copy is first seen at the
    // 3rd edge, key_held falls DEB edges after that.
    task automatic press_release(input logic [15:0] mask, input int hold);
        logic [3:0] exp_code;
        logic [3:0] exp_row;
        int  waited;
        bit  seen;
        bit  held_drop;
        int  extra;
        exp_code = ref_code(mask);
        exp_row  = ref_row(mask);
        pressed  = mask;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 200) begin
            tick();
            waited++;
            if (kp.key_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL press_timeout mask=%h no key_valid within 200 cycles", mask);
        end else begin
            checks++;
            if (kp.key_code !== exp_code) begin
                errors++;
                $display("FAIL press_code mask=%h got=%0d exp=%0d", mask, kp.key_code, exp_code);
            end
            checks++;
            if (kp.key_held !== 1'b1) begin
                errors++;
                $display("FAIL press_held mask=%h got=%b exp=1", mask, kp.key_held);
            end
            checks++;
            if (!window_ok(exp_row)) begin
                errors++;
                $display("FAIL press_window mask=%h got=early_accept exp=row %b stable for %0d edges",
                         mask, exp_row, DEB + 1);
            end
        end
        held_drop = 1'b0;
        extra = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (kp.key_held !== 1'b1) held_drop = 1'b1;
            if (kp.key_valid) extra++;
        end
        checks++;
        if (held_drop) begin
            errors++;
            $display("FAIL hold_level mask=%h got=key_held dropped exp=high while pressed", mask);
        end
        pressed = '0;
        for (int t = 1; t <= DEB + 3; t++) begin
            tick();
            if (kp.key_valid) extra++;
            if (t == DEB + 2) begin
                checks++;
                if (kp.key_held !== 1'b1) begin
                    errors++;
                    $display("FAIL release_early mask=%h got=%b exp=1", mask, kp.key_held);
                end
            end
            if (t == DEB + 3) begin
                checks++;
                if (kp.key_held !== 1'b0) begin
                    errors++;
                    $display("FAIL release_late mask=%h got=%b exp=0", mask, kp.key_held);
                end
            end
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL no_repeat mask=%h got=%0d extra pulses exp=0", mask, extra);
        end
        checks++;
        if (kp.key_code !== exp_code) begin
            errors++;
            $display("FAIL code_kept mask=%h got=%0d exp=%0d", mask, kp.key_code, exp_code);
        end
        repeat (6) tick();
    endtask

    task automatic wait_release(input string name);
        int w;
        w = 0;
        pressed = '0;
        while (kp.key_held === 1'b1 && w < 60) begin
            tick();
            w++;
        end
        checks++;
        if (kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL %s_release got=%b exp=0", name, kp.key_held);
        end
        repeat (4) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [3:0] exp_col;
        pressed = '0;
        do_reset();
        checks++;
        if (kp.column !== 4'b1110 || kp.key_code !== 4'd0 || kp.key_valid !== 1'b0 || kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got=col %b code %0d v %b h %b exp=col 1110 code 0 v 0 h 0",
                     kp.column, kp.key_code, kp.key_valid, kp.key_held);
        end
        repeat (6) tick();
        checks++;
        if (kp.column !== 4'b1101) begin
            errors++;
            $display("FAIL reset_midscan_col got=%b exp=1101", kp.column);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (kp.column !== 4'b1110 || kp.key_code !== 4'd0 || kp.key_valid !== 1'b0 || kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got=col %b code %0d v %b h %b exp=col 1110 code 0 v 0 h 0",
                     kp.column, kp.key_code, kp.key_valid, kp.key_held);
        end
        repeat (3) tick();
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_col = ~(4'b0001 << ((k / SCAN) % 4));
            checks++;
            if (kp.column !== exp_col) begin
                errors++;
                $display("FAIL rotate_k%0d got=%b exp=%b", k, kp.column, exp_col);
            end
        end
    endtask

    task automatic test_keymap();
        for (int i = 0; i < 16; i++) press_release(16'(1) << i, 5);
    endtask

    // '5' is (r1,c1). After reset, column 1 is sampled at edge 8. The press
    // starts after edge 5 so that sample sees it; the row goes high again
    // after edge 8, the delayed copy shows it at edge 11, debounce aborts and
    // the scan moves to column 2. Column 1 is next sampled at edge 27 (3 more
    // dwells of 4 plus its own), by which time the key is steady (from 20),
    // so the single pulse lands at edge 27 + 8 = 35.
    task automatic test_bounce();
        int first;
        int pulses;
        logic [3:0] code_at;
        pressed = '0;
        do_reset();
        first = 0;
        pulses = 0;
        code_at = 4'd0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (kp.key_valid) begin
                pulses++;
                if (first == 0) begin
                    first = k;
                    code_at = kp.key_code;
                end
            end
            if (k == 5 || k == 10 || k == 15 || k == 20) pressed = 16'(1) << 5;
            if (k == 8 || k == 13 || k == 18) pressed = '0;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_pulses got=%0d exp=1", pulses);
        end
        checks++;
        if (first != 35) begin
            errors++;
            $display("FAIL bounce_latency got=%0d exp=35", first);
        end
        checks++;
        if (code_at !== 4'd5) begin
            errors++;
            $display("FAIL bounce_code got=%0d exp=5", code_at);
        end
        wait_release("bounce");
    endtask

    task automatic test_hold();
        press_release(16'(1) << 15, 200);
    endtask

    task automatic test_two_keys();
        logic [15:0] m;
        int  w;
        m = (16'(1) << 8) | (16'(1) << 0);
        pressed = m;
        w = 0;
        while (kp.key_valid !== 1'b1 && w < 200) begin
            tick();
            w++;
        end
        checks++;
        if (kp.key_valid !== 1'b1 || kp.key_code !== ref_code(m)) begin
            errors++;
            $display("FAIL two_keys_code got=v %b code %0d exp=v 1 code %0d",
                     kp.key_valid, kp.key_code, ref_code(m));
        end
        checks++;
        if (!window_ok(ref_row(m))) begin
            errors++;
            $display("FAIL two_keys_window got=early_accept exp=row %b stable", ref_row(m));
        end
        rst = 1'b1;
        #1;
        checks++;
        if (kp.key_held !== 1'b0 || kp.key_code !== 4'd0 || kp.column !== 4'b1110) begin
            errors++;
            $display("FAIL reset_while_held got=h %b code %0d col %b exp=h 0 code 0 col 1110",
                     kp.key_held, kp.key_code, kp.column);
        end
        pressed = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    // '0' is (r3,c1): after reset, column 1 is sampled at edge 2*SCAN = 8 and
    // accepted DEB edges later, at edge 16. The first reset lands at edge 12.
    task automatic test_reset_debounce();
        int pulses;
        int first;
        logic [3:0] code_at;
        logic held_at;
        pressed = 16'(1) << 13;
        do_reset();
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (kp.key_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL rstdb_early_pulse got=%0d exp=0", pulses);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (kp.key_valid !== 1'b0 || kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL rstdb_async got=v %b h %b exp=v 0 h 0", kp.key_valid, kp.key_held);
        end
        repeat (3) tick();
        rst = 1'b0;
        first = 0;
        code_at = 4'hF;
        held_at = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (kp.key_valid && first == 0) begin
                first = k;
                code_at = kp.key_code;
                held_at = kp.key_held;
            end
        end
        checks++;
        if (first != 2 * SCAN + DEB) begin
            errors++;
            $display("FAIL rstdb_latency got=%0d exp=%0d", first, 2 * SCAN + DEB);
        end
        checks++;
        if (code_at !== 4'd0 || held_at !== 1'b1) begin
            errors++;
            $display("FAIL rstdb_code got=code %0d h %b exp=code 0 h 1", code_at, held_at);
        end
        wait_release("rstdb");
    endtask

    task automatic test_random();
        int idx;
        int hold;
        int gap;
        for (int n = 0; n < 8; n++) begin
            idx  = $urandom_range(0, 15);
            hold = $urandom_range(0, 30);
            gap  = $urandom_range(0, 20);
            repeat (gap) tick();
            press_release(16'(1) << idx, hold);
        end
    endtask

    task automatic test_pulse_width();
        checks++;
        if (max_valid_run != 1) begin
            errors++;
            $display("FAIL pulse_width got=%0d exp=1", max_valid_run);
        end
    endtask

    initial begin
        test_reset();
        test_keymap();
        test_bounce();
        test_hold();
        test_two_keys();
        test_reset_debounce();
        test_random();
        test_pulse_width();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
